// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner issuing single-outstanding imem reads and delivering instructions to IF/ID
module instr_fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int PC_INC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_in,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] instr_out,
  output logic              hit_fetch_out,
  output logic [15:0]       fetch_cnt
);
  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;
  state_t state, n_state;
  logic [ADDR_W-1:0] pc, n_pc, n_addr, n_ao, hold_addr, n_ha, pc_inc;
  logic [DATA_W-1:0] n_io, hold_data, n_hd;
  logic [15:0] n_cnt;
  logic n_req, n_hit, done, pending;
  assign done = imem_req && imem_ready;
  assign pending = imem_req && !imem_ready;
  assign pc_inc = pc + ADDR_W'(PC_INC);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH;
      pc <= RESET_PC;
      imem_req <= 1'b0;
      imem_addr <= RESET_PC;
      addr_out <= '0;
      instr_out <= '0;
      hit_fetch_out <= 1'b0;
      fetch_cnt <= '0;
      hold_addr <= '0;
      hold_data <= '0;
    end else begin
      state <= n_state;
      pc <= n_pc;
      imem_req <= n_req;
      imem_addr <= n_addr;
      addr_out <= n_ao;
      instr_out <= n_io;
      hit_fetch_out <= n_hit;
      fetch_cnt <= n_cnt;
      hold_addr <= n_ha;
      hold_data <= n_hd;
    end
  end
  always_comb begin
    n_state = state;
    n_pc = pc;
    n_req = imem_req;
    n_addr = imem_addr;
    n_ao = addr_out;
    n_io = instr_out;
    n_hit = 1'b0;
    n_cnt = fetch_cnt;
    n_ha = hold_addr;
    n_hd = hold_data;
    if (redirect_valid) begin
      // an unfinished request must be drained before the new target is fetched
      n_pc = redirect_addr;
      n_state = pending ? DRAIN : FETCH;
      n_req = 1'b1;
      n_addr = pending ? imem_addr : redirect_addr;
    end else begin
      case (state)
        FETCH: begin
          if (done && stall_in) begin
            n_ha = pc;
            n_hd = imem_rdata;
            n_pc = pc_inc;
            n_req = 1'b0;
            n_state = HOLD;
          end else if (done) begin
            n_ao = pc;
            n_io = imem_rdata;
            n_hit = 1'b1;
            n_cnt = fetch_cnt + 16'd1;
            n_pc = pc_inc;
            n_addr = pc_inc;
          end else if (!imem_req) begin
            n_req = 1'b1;
            n_addr = pc;
          end
        end
        HOLD: begin
          if (!stall_in) begin
            n_ao = hold_addr;
            n_io = hold_data;
            n_hit = 1'b1;
            n_cnt = fetch_cnt + 16'd1;
            n_req = 1'b1;
            n_addr = pc;
            n_state = FETCH;
          end
        end
        DRAIN: begin
          if (done) begin
            n_addr = pc;
            n_state = FETCH;
          end
        end
        default: n_state = FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed vector table plus ready-throttling sequence for instr_fetch_unit
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0, stall_in = 1'b0, redirect_valid = 1'b0, imem_ready = 1'b0;
  logic [15:0] redirect_addr = '0;
  logic imem_req, hit_fetch_out;
  logic [15:0] imem_addr, imem_rdata, addr_out, instr_out, fetch_cnt;
  int total = 0, bad = 0;
  typedef struct packed {
    logic rn, st, rv;
    logic [15:0] ra;
    logic rdy, req;
    logic [15:0] ia;
    logic hit;
    logic [15:0] ao, io, cnt;
  } vec_t;
  vec_t vec[$];
  always #5 clk = ~clk;
  assign imem_rdata = imem_addr ^ 16'hA5B5;
  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .addr_out(addr_out),
    .instr_out(instr_out), .hit_fetch_out(hit_fetch_out), .fetch_cnt(fetch_cnt)
  );
  task automatic add(input logic rn, st, rv, input logic [15:0] ra, input logic rdy, req,
                     input logic [15:0] ia, input logic hit, input logic [15:0] ao, io, cnt);
    vec.push_back({rn, st, rv, ra, rdy, req, ia, hit, ao, io, cnt});
  endtask
  task automatic step(input logic rn, st, rv, input logic [15:0] ra, input logic rdy);
    @(negedge clk);
    rst_n = rn;
    stall_in = st;
    redirect_valid = rv;
    redirect_addr = ra;
    imem_ready = rdy;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic req, input logic [15:0] ia, input logic hit,
                       input logic [15:0] ao, io, cnt);
    total++;
    if ({imem_req, imem_addr, hit_fetch_out, addr_out, instr_out, fetch_cnt} !== {req, ia, hit, ao, io, cnt}) begin
      bad++;
      $display("FAIL %s: got req=%b addr=%h hit=%b ao=%h io=%h cnt=%0d, want req=%b addr=%h hit=%b ao=%h io=%h cnt=%0d",
               name, imem_req, imem_addr, hit_fetch_out, addr_out, instr_out, fetch_cnt, req, ia, hit, ao, io, cnt);
    end
  endtask
  initial begin
    // rn st rv ra rdy | req ia hit ao io cnt
    add(0,0,0,16'h0000,1, 0,16'h0000,0,16'h0000,16'h0000,0);
    add(0,0,0,16'h0000,1, 0,16'h0000,0,16'h0000,16'h0000,0);
    add(1,0,0,16'h0000,1, 1,16'h0000,0,16'h0000,16'h0000,0);
    add(1,0,0,16'h0000,1, 1,16'h0001,1,16'h0000,16'hA5B5,1);
    add(1,0,0,16'h0000,1, 1,16'h0002,1,16'h0001,16'hA5B4,2);
    add(1,0,0,16'h0000,1, 1,16'h0003,1,16'h0002,16'hA5B7,3);
    add(1,0,0,16'h0000,1, 1,16'h0004,1,16'h0003,16'hA5B6,4);
    add(1,0,0,16'h0000,0, 1,16'h0004,0,16'h0003,16'hA5B6,4);
    add(1,0,0,16'h0000,0, 1,16'h0004,0,16'h0003,16'hA5B6,4);
    add(1,0,0,16'h0000,1, 1,16'h0005,1,16'h0004,16'hA5B1,5);
    add(1,0,0,16'h0000,0, 1,16'h0005,0,16'h0004,16'hA5B1,5);
    add(1,0,0,16'h0000,0, 1,16'h0005,0,16'h0004,16'hA5B1,5);
    add(1,0,1,16'h0200,0, 1,16'h0005,0,16'h0004,16'hA5B1,5);
    add(1,0,0,16'h0000,0, 1,16'h0005,0,16'h0004,16'hA5B1,5);
    add(1,0,0,16'h0000,1, 1,16'h0200,0,16'h0004,16'hA5B1,5);
    add(1,0,0,16'h0000,1, 1,16'h0201,1,16'h0200,16'hA7B5,6);
    add(1,0,1,16'h0010,1, 1,16'h0010,0,16'h0200,16'hA7B5,6);
    add(1,1,0,16'h0000,1, 0,16'h0010,0,16'h0200,16'hA7B5,6);
    add(1,1,0,16'h0000,1, 0,16'h0010,0,16'h0200,16'hA7B5,6);
    add(1,1,0,16'h0000,1, 0,16'h0010,0,16'h0200,16'hA7B5,6);
    add(1,1,0,16'h0000,1, 0,16'h0010,0,16'h0200,16'hA7B5,6);
    add(1,1,0,16'h0000,1, 0,16'h0010,0,16'h0200,16'hA7B5,6);
    add(1,0,0,16'h0000,1, 1,16'h0011,1,16'h0010,16'hA5A5,7);
    add(1,0,0,16'h0000,1, 1,16'h0012,1,16'h0011,16'hA5A4,8);
    add(1,1,1,16'h0300,1, 1,16'h0300,0,16'h0011,16'hA5A4,8);
    add(1,0,0,16'h0000,0, 1,16'h0300,0,16'h0011,16'hA5A4,8);
    add(1,0,1,16'hFFFF,1, 1,16'hFFFF,0,16'h0011,16'hA5A4,8);
    add(1,0,0,16'h0000,1, 1,16'h0000,1,16'hFFFF,16'h5A4A,9);
    add(1,0,0,16'h0000,0, 1,16'h0000,0,16'hFFFF,16'h5A4A,9);
    add(0,0,0,16'h0000,0, 0,16'h0000,0,16'h0000,16'h0000,0);
    add(1,0,0,16'h0000,1, 1,16'h0000,0,16'h0000,16'h0000,0);
    add(1,0,0,16'h0000,0, 1,16'h0000,0,16'h0000,16'h0000,0);
    add(1,0,0,16'h0000,1, 1,16'h0001,1,16'h0000,16'hA5B5,1);
    add(1,1,0,16'h0000,1, 0,16'h0001,0,16'h0000,16'hA5B5,1);
    add(1,1,1,16'h0040,0, 1,16'h0040,0,16'h0000,16'hA5B5,1);
    add(1,0,0,16'h0000,1, 1,16'h0041,1,16'h0040,16'hA5F5,2);
    for (int i = 0; i < vec.size(); i++) begin
      step(vec[i].rn, vec[i].st, vec[i].rv, vec[i].ra, vec[i].rdy);
      check($sformatf("vec%0d", i), vec[i].req, vec[i].ia, vec[i].hit, vec[i].ao, vec[i].io, vec[i].cnt);
    end
    // ready every third cycle: address held across waits, exactly one pulse per completion
    for (int k = 0; k < 9; k++) begin
      int d;
      logic [15:0] ia;
      d = (k + 1) / 3;
      ia = 16'h0041 + 16'(d);
      step(1, 0, 0, 16'h0000, k % 3 == 2);
      check($sformatf("slow%0d", k), 1'b1, ia, k % 3 == 2, d == 0 ? 16'h0040 : ia - 16'd1,
            d == 0 ? 16'hA5F5 : (ia - 16'd1) ^ 16'hA5B5, 16'(2 + d));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
